ram_port_arbiter: RTL and testbench
===================================

Name: ram_port_arbiter

Overview:
Shares one port of the on-chip dual-port RAM between two word-oriented requesters. The typical pairing is the AHB-to-RAM bridge (m0) and the RAM-to-AHB transfer engine (m1). This frees the second RAM port for other use.
- Arbitration is round-robin with burst locking and a bounded burst length.
- Read data returns with the fixed one-cycle latency of the RAM (registered address, unregistered q).

Parameters:
ADDR_BITS, 12, byte-address width of the RAM; the word address is ADDR_BITS-2 bits.
MAX_BURST, 8, maximum consecutive locked grants to one owner while the other requester is waiting; legal range 1..255.

Ports:
sys_clock  in  1  sole clock; all state is on the rising edge.
resetn  in  1  asynchronous, active-low reset.
m0_req  in  1  m0 has a transaction; fields must stay stable until m0_gnt.
m0_lock  in  1  m0 requests a hold on ownership after this beat (not the last beat of a burst).
m0_addr  in  ADDR_BITS-2  m0 word address.
m0_byteena  in  4  m0 byte enables (writes only).
m0_data  in  32  m0 write data.
m0_wren  in  1  1 = write, 0 = read.
m0_gnt  out  1  combinational; beat accepted this cycle.
m0_rvalid  out  1  m0 read data valid.
m0_rdata  out  32  m0 read data.
m1_req, m1_lock, m1_addr, m1_byteena, m1_data, m1_wren, m1_gnt, m1_rvalid, m1_rdata  same as m0, for requester 1.
ram_addr  out  ADDR_BITS-2  RAM word address.
ram_byteena  out  4  RAM byte enables.
ram_data  out  32  RAM write data.
ram_wren  out  1  RAM write strobe.
ram_rden  out  1  RAM read strobe.
ram_q  in  32  RAM read data, valid the cycle after ram_rden.

Behaviour:
- State registers:
  - last (index of the most recent grant)
  - lock_act
  - owner
  - beat_cnt, width $clog2(MAX_BURST+1)
  - rd_pend[1:0]
- Reset values: last=1 (so m0 wins the first tie), lock_act=0, owner=0, beat_cnt=0, rd_pend=0, sel=0.
- Output reset values: all rvalid=0; ram_wren=0, ram_rden=0; gnt=0 while no req.
- Grant decision (combinational, at most one gnt per cycle):
  1. lock_act && req[owner] && (beat_cnt<MAX_BURST || !req[other]) -> grant owner.
  2. Otherwise, exactly one req -> grant that requester.
  3. Both req -> grant !last.
  4. No req -> no grant.
- RAM drive:
  - ram_wren = granted && wren[g]; ram_rden = granted && !wren[g]; both 0 otherwise.
  - addr/data/byteena are muxed from the granted requester. When idle they are muxed from the last-granted requester (registered sel); never X.
- On each grant (clocked): last<=g.
  - lock[g]=1: lock_act<=1, owner<=g; beat_cnt<=beat_cnt+1 if owner==g && lock_act, else 1. beat_cnt saturates at MAX_BURST.
  - lock[g]=0: lock_act<=0, beat_cnt<=0.
- Lock release without a grant:
  - If req[owner]=0 while lock_act: lock_act<=0 and beat_cnt<=0. Locks never survive an idle cycle of the owner.
  - Preemption (owner requesting, beat_cnt==MAX_BURST, other requesting): the other is granted; lock_act is then cleared by the other's grant (its lock input decides).
- Read return:
  - rd_pend[g]<=1 for a granted read; all other bits <=0 each cycle.
  - mX_rvalid = rd_pend[X]; mX_rdata = ram_q (qualified by rvalid).
  - Latency is exactly 1 cycle after gnt, independent of subsequent grants.
- Back-to-back ordering: a write followed by a read of the same word in the next cycle returns the new data, per RAM write-then-read ordering.
- Reset mid-operation: pending reads are dropped (no rvalid) and lock is lost; requesters must reissue.
- Write beats produce no response.

Decomposition:
- Package ram_arb_pkg:
  - owner index constants M0=0, M1=1.
  - A function beat_w(MAX_BURST) returning the counter width.
  - A typedef for the request bundle {addr, byteena, data, wren, lock}.
- No sub-module; grant logic and datapath mux fit in one module of roughly 200 lines.

Test Plan:
- Single read: m0 read addr 0x010 after memory preloaded 0xA5A5_0001 -> m0_gnt same cycle, ram_rden=1, m0_rvalid one cycle later with rdata 0xA5A5_0001, m1_rvalid=0.
- Tie-break: both req from reset in the same cycle -> m0 granted first, m1 next cycle, then alternating (m0,m1,m0,m1) for 4 cycles with both requesting.
- Burst lock: m1 issues 5 locked beats (lock=1 x4, last lock=0) while m0 idle, then m0 requests mid-burst -> m1 keeps gnt for all 5 consecutive beats, m0 granted the cycle after the last beat.
- Preemption: MAX_BURST=8, m1 holds lock and requests continuously, m0 requesting from the start -> m1 gets 8 grants, m0 gets 1, then m1 re-acquires.
- Idle releases lock: m0 locked beat, m0_req low for 1 cycle with m1 requesting -> m1 granted that cycle, lock_act=0.
- Async reset during pending read: assert resetn=0 the cycle after a granted read -> m0_rvalid stays 0, all gnt/strobes 0 during reset, first post-reset tie goes to m0.

Source files
------------

// File: rtl/ram_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ram_arb_pkg
// Purpose  : Shared constants, types and helpers for the RAM port arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package ram_arb_pkg;

    // Requester indices
    localparam logic M0 = 1'b0;
    localparam logic M1 = 1'b1;

    // Widest word address a request bundle can carry; narrower RAMs zero-extend
    localparam int WADDR_MAX = 30;

    // Width of the burst beat counter that must hold 0..max_burst
    function automatic int beat_w(input int max_burst);
        return $clog2(max_burst + 1);
    endfunction

    // One requester's transaction fields
    typedef struct packed {
        logic [WADDR_MAX-1:0] addr;
        logic [3:0]           byteena;
        logic [31:0]          data;
        logic                 wren;
        logic                 lock;
    } req_bundle_t;

endpackage
`default_nettype wire

// File: rtl/ram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ram_port_arbiter
// Purpose  : Round-robin arbiter sharing one RAM port between two word
//            requesters, with burst locking bounded by MAX_BURST and a fixed
//            one-cycle read return.
// Revision : 1.0 - initial release
// ============================================================================
module ram_port_arbiter
    import ram_arb_pkg::*;
#(
    parameter int ADDR_BITS = 12,
    parameter int MAX_BURST = 8
) (
    input  logic                 sys_clock,
    input  logic                 resetn,

    input  logic                 m0_req,
    input  logic                 m0_lock,
    input  logic [ADDR_BITS-3:0] m0_addr,
    input  logic [3:0]           m0_byteena,
    input  logic [31:0]          m0_data,
    input  logic                 m0_wren,
    output logic                 m0_gnt,
    output logic                 m0_rvalid,
    output logic [31:0]          m0_rdata,

    input  logic                 m1_req,
    input  logic                 m1_lock,
    input  logic [ADDR_BITS-3:0] m1_addr,
    input  logic [3:0]           m1_byteena,
    input  logic [31:0]          m1_data,
    input  logic                 m1_wren,
    output logic                 m1_gnt,
    output logic                 m1_rvalid,
    output logic [31:0]          m1_rdata,

    output logic [ADDR_BITS-3:0] ram_addr,
    output logic [3:0]           ram_byteena,
    output logic [31:0]          ram_data,
    output logic                 ram_wren,
    output logic                 ram_rden,
    input  logic [31:0]          ram_q
);

    localparam int                c_AW       = ADDR_BITS - 2;
    localparam int                c_BEAT_W   = beat_w(MAX_BURST);
    localparam logic [c_BEAT_W-1:0] c_MAX_BEAT = c_BEAT_W'(MAX_BURST);
    localparam logic [c_BEAT_W-1:0] c_BEAT_ONE = c_BEAT_W'(1);

    // Arbitration state
    logic                r_last;
    logic                r_sel;
    logic                r_lock_act;
    logic                r_owner;
    logic [c_BEAT_W-1:0] r_beat_cnt;
    logic [1:0]          r_rd_pend;

    // Decision and datapath nets
    logic [1:0]  w_req;
    req_bundle_t w_rq [2];
    req_bundle_t w_sel_rq;
    logic        w_granted;
    logic        w_g;
    logic        w_idx;
    logic        w_other;
    logic        w_rden;
    logic        w_unused_addr_hi;

    // Requests are ignored while reset is held so no strobe escapes
    assign w_req   = {m1_req, m0_req} & {2{resetn}};
    assign w_other = ~r_owner;

    // Pack each requester's fields into a common bundle
    always_comb begin
        w_rq[0]         = '0;
        w_rq[1]         = '0;
        w_rq[0].addr    = WADDR_MAX'(m0_addr);
        w_rq[0].byteena = m0_byteena;
        w_rq[0].data    = m0_data;
        w_rq[0].wren    = m0_wren;
        w_rq[0].lock    = m0_lock;
        w_rq[1].addr    = WADDR_MAX'(m1_addr);
        w_rq[1].byteena = m1_byteena;
        w_rq[1].data    = m1_data;
        w_rq[1].wren    = m1_wren;
        w_rq[1].lock    = m1_lock;
    end

    // Grant decision: locked owner first (until its burst budget runs out
    // while the other waits), then the lone requester, then round-robin
    always_comb begin
        w_granted = 1'b0;
        w_g       = M0;
        if (r_lock_act && w_req[r_owner] &&
            ((r_beat_cnt < c_MAX_BEAT) || !w_req[w_other])) begin
            w_granted = 1'b1;
            w_g       = r_owner;
        end else begin
            case (w_req)
                2'b01: begin
                    w_granted = 1'b1;
                    w_g       = M0;
                end
                2'b10: begin
                    w_granted = 1'b1;
                    w_g       = M1;
                end
                2'b11: begin
                    w_granted = 1'b1;
                    w_g       = ~r_last;
                end
                default: begin
                    w_granted = 1'b0;
                    w_g       = M0;
                end
            endcase
        end
    end

    // RAM fields come from the granted requester, or the last one when idle
    assign w_idx            = w_granted ? w_g : r_sel;
    assign w_sel_rq         = w_rq[w_idx];
    assign w_unused_addr_hi = |w_sel_rq.addr[WADDR_MAX-1:c_AW];

    assign ram_addr    = w_sel_rq.addr[c_AW-1:0];
    assign ram_byteena = w_sel_rq.byteena;
    assign ram_data    = w_sel_rq.data;
    assign ram_wren    = w_granted & w_sel_rq.wren;
    assign w_rden      = w_granted & ~w_sel_rq.wren;
    assign ram_rden    = w_rden;

    assign m0_gnt    = w_granted & (w_g == M0);
    assign m1_gnt    = w_granted & (w_g == M1);
    assign m0_rvalid = r_rd_pend[0];
    assign m1_rvalid = r_rd_pend[1];
    assign m0_rdata  = ram_q;
    assign m1_rdata  = ram_q;

    // Round-robin pointer, idle mux select and burst-lock bookkeeping
    always_ff @(posedge sys_clock or negedge resetn) begin
        if (!resetn) begin
            r_last     <= M1;
            r_sel      <= M0;
            r_lock_act <= 1'b0;
            r_owner    <= M0;
            r_beat_cnt <= '0;
        end else if (w_granted) begin
            r_last <= w_g;
            r_sel  <= w_g;
            if (w_sel_rq.lock) begin
                r_lock_act <= 1'b1;
                r_owner    <= w_g;
                if (r_lock_act && (r_owner == w_g)) begin
                    if (r_beat_cnt != c_MAX_BEAT) begin
                        r_beat_cnt <= r_beat_cnt + c_BEAT_ONE;
                    end
                end else begin
                    r_beat_cnt <= c_BEAT_ONE;
                end
            end else begin
                r_lock_act <= 1'b0;
                r_beat_cnt <= '0;
            end
        end else if (r_lock_act && !w_req[r_owner]) begin
            // An owner that stops requesting for even one cycle loses the lock
            r_lock_act <= 1'b0;
            r_beat_cnt <= '0;
        end
    end

    // Flag which requester receives ram_q on the cycle after its read grant
    always_ff @(posedge sys_clock or negedge resetn) begin
        if (!resetn) begin
            r_rd_pend <= '0;
        end else begin
            r_rd_pend <= {w_rden & w_g, w_rden & ~w_g};
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_ram_port_arbiter
// Purpose  : Self-checking bench for ram_port_arbiter: directed scenarios with
//            literal grant sequences plus randomized traffic against a
//            behavioural model and a RAM model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ram_port_arbiter;

    localparam int ADDR_BITS = 12;
    localparam int MAX_BURST = 8;
    localparam int AW        = ADDR_BITS - 2;
    localparam int DEPTH     = 1 << AW;

    logic          sys_clock = 1'b0;
    logic          resetn;
    logic [1:0]    req;
    logic [1:0]    lock;
    logic [1:0]    wren;
    logic [AW-1:0] addr [2];
    logic [3:0]    be   [2];
    logic [31:0]   wdat [2];

    logic          m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
    logic [31:0]   m0_rdata, m1_rdata;
    logic [AW-1:0] ram_addr;
    logic [3:0]    ram_byteena;
    logic [31:0]   ram_data;
    logic          ram_wren, ram_rden;
    logic [31:0]   ram_q;

    logic [31:0]   mem    [DEPTH];
    logic [31:0]   shadow [DEPTH];

    int            n_cmp = 0;
    int            n_err = 0;
    int            ghist[$];
    int            mhist[$];
    logic [1:0]    seen_gnt = 2'b00;

    // Behavioural model state
    int            md_last;
    int            md_sel;
    int            md_lock_owner;
    int            md_run;
    logic [1:0]    md_pend;
    logic [31:0]   md_pdata [2];

    ram_port_arbiter #(.ADDR_BITS(ADDR_BITS), .MAX_BURST(MAX_BURST)) dut (
        .sys_clock   (sys_clock),
        .resetn      (resetn),
        .m0_req      (req[0]),
        .m0_lock     (lock[0]),
        .m0_addr     (addr[0]),
        .m0_byteena  (be[0]),
        .m0_data     (wdat[0]),
        .m0_wren     (wren[0]),
        .m0_gnt      (m0_gnt),
        .m0_rvalid   (m0_rvalid),
        .m0_rdata    (m0_rdata),
        .m1_req      (req[1]),
        .m1_lock     (lock[1]),
        .m1_addr     (addr[1]),
        .m1_byteena  (be[1]),
        .m1_data     (wdat[1]),
        .m1_wren     (wren[1]),
        .m1_gnt      (m1_gnt),
        .m1_rvalid   (m1_rvalid),
        .m1_rdata    (m1_rdata),
        .ram_addr    (ram_addr),
        .ram_byteena (ram_byteena),
        .ram_data    (ram_data),
        .ram_wren    (ram_wren),
        .ram_rden    (ram_rden),
        .ram_q       (ram_q)
    );

    always #5 sys_clock = ~sys_clock;

    // RAM: registered address, one-cycle read data
    always @(posedge sys_clock) begin
        if (ram_wren) begin
            for (int b = 0; b < 4; b++) begin
                if (ram_byteena[b]) mem[ram_addr][8*b +: 8] <= ram_data[8*b +: 8];
            end
        end
        if (ram_rden) ram_q <= mem[ram_addr];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            if (n_err <= 40)
                $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic int dut_code();
        if (m0_gnt && m1_gnt) return 3;
        if (m0_gnt) return 0;
        if (m1_gnt) return 1;
        return -1;
    endfunction

    function automatic void model_reset();
        md_last       = 1;
        md_sel        = 0;
        md_lock_owner = -1;
        md_run        = 0;
        md_pend       = 2'b00;
    endfunction

    // Which requester the rules select this cycle (-1 = nobody)
    function automatic int model_grant();
        int lo;
        lo = md_lock_owner;
        if (lo >= 0 && req[lo] && (md_run < MAX_BURST || !req[1-lo])) return lo;
        if (req == 2'b01) return 0;
        if (req == 2'b10) return 1;
        if (req == 2'b11) return 1 - md_last;
        return -1;
    endfunction

    // Compare DUT against the model once per cycle, then advance the model
    always @(negedge sys_clock) begin
        int   g;
        int   idx;
        logic ew, er;
        if (!resetn) begin
            chk("rst_m0_gnt", {31'd0, m0_gnt}, 32'd0);
            chk("rst_m1_gnt", {31'd0, m1_gnt}, 32'd0);
            chk("rst_wren", {31'd0, ram_wren}, 32'd0);
            chk("rst_rden", {31'd0, ram_rden}, 32'd0);
            chk("rst_m0_rvalid", {31'd0, m0_rvalid}, 32'd0);
            chk("rst_m1_rvalid", {31'd0, m1_rvalid}, 32'd0);
            model_reset();
            ghist.push_back(dut_code());
            mhist.push_back(-1);
            seen_gnt = 2'b00;
        end else begin
            chk("m0_rvalid", {31'd0, m0_rvalid}, {31'd0, md_pend[0]});
            chk("m1_rvalid", {31'd0, m1_rvalid}, {31'd0, md_pend[1]});
            if (md_pend[0]) chk("m0_rdata", m0_rdata, md_pdata[0]);
            if (md_pend[1]) chk("m1_rdata", m1_rdata, md_pdata[1]);
            g  = model_grant();
            ew = 1'b0;
            er = 1'b0;
            if (g >= 0) begin
                ew = wren[g];
                er = !wren[g];
            end
            chk("m0_gnt", {31'd0, m0_gnt}, {31'd0, g == 0});
            chk("m1_gnt", {31'd0, m1_gnt}, {31'd0, g == 1});
            chk("ram_wren", {31'd0, ram_wren}, {31'd0, ew});
            chk("ram_rden", {31'd0, ram_rden}, {31'd0, er});
            idx = (g >= 0) ? g : md_sel;
            chk("ram_addr", 32'(ram_addr), 32'(addr[idx]));
            chk("ram_byteena", 32'(ram_byteena), 32'(be[idx]));
            chk("ram_data", ram_data, wdat[idx]);
            ghist.push_back(dut_code());
            mhist.push_back(g);
            seen_gnt = {m1_gnt, m0_gnt};

            md_pend = 2'b00;
            if (g >= 0) begin
                md_last = g;
                md_sel  = g;
                if (wren[g]) begin
                    for (int b = 0; b < 4; b++) begin
                        if (be[g][b]) shadow[addr[g]][8*b +: 8] = wdat[g][8*b +: 8];
                    end
                end else begin
                    md_pend[g]  = 1'b1;
                    md_pdata[g] = shadow[addr[g]];
                end
                if (lock[g]) begin
                    if (md_lock_owner == g) md_run = (md_run < MAX_BURST) ? md_run + 1 : MAX_BURST;
                    else                    md_run = 1;
                    md_lock_owner = g;
                end else begin
                    md_lock_owner = -1;
                    md_run        = 0;
                end
            end else if (md_lock_owner >= 0 && !req[md_lock_owner]) begin
                md_lock_owner = -1;
                md_run        = 0;
            end
        end
    end

    task automatic step();
        @(posedge sys_clock);
        #1;
    endtask

    task automatic set_m(input int m, input logic r, input logic lk, input logic w,
                         input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] b);
        req[m]  = r;
        lock[m] = lk;
        wren[m] = w;
        addr[m] = a;
        wdat[m] = d;
        be[m]   = b;
    endtask

    task automatic check_seq(input string name, input int start, input int exp_q[$]);
        for (int i = 0; i < exp_q.size(); i++) begin
            chk({name, "_dut"}, ghist[start+i], exp_q[i]);
            chk({name, "_mdl"}, mhist[start+i], exp_q[i]);
        end
    endtask

    initial begin
        int s;
        int q[$];
        int preq;
        int plock;
        resetn = 1'b0;
        req    = '0;
        lock   = '0;
        wren   = '0;
        for (int m = 0; m < 2; m++) begin
            addr[m] = '0;
            be[m]   = '0;
            wdat[m] = '0;
        end
        for (int i = 0; i < DEPTH; i++) begin
            mem[i]    = $urandom;
            shadow[i] = mem[i];
        end
        mem[16]    = 32'hA5A5_0001;
        shadow[16] = 32'hA5A5_0001;
        repeat (3) step();
        chk("reset_m0_rvalid", {31'd0, m0_rvalid}, 32'd0);
        chk("reset_rden", {31'd0, ram_rden}, 32'd0);

        // Single read from m0
        resetn = 1'b1;
        set_m(0, 1'b1, 1'b0, 1'b0, 10'h010, 32'd0, 4'hF);
        #1;
        chk("rd_gnt", {31'd0, m0_gnt}, 32'd1);
        chk("rd_rden", {31'd0, ram_rden}, 32'd1);
        step();
        req[0] = 1'b0;
        chk("rd_rvalid", {31'd0, m0_rvalid}, 32'd1);
        chk("rd_rdata", m0_rdata, 32'hA5A5_0001);
        chk("rd_m1_rvalid", {31'd0, m1_rvalid}, 32'd0);
        step();

        // Tie-break from reset, then alternation
        resetn = 1'b0;
        step();
        step();
        resetn = 1'b1;
        set_m(0, 1'b1, 1'b0, 1'b0, 10'h001, 32'd0, 4'hF);
        set_m(1, 1'b1, 1'b0, 1'b0, 10'h002, 32'd0, 4'hF);
        s = ghist.size();
        repeat (6) step();
        req = '0;
        step();
        q = '{0, 1, 0, 1, 0, 1};
        check_seq("tie", s, q);

        // Five-beat locked burst from m1; m0 arrives mid-burst
        s = ghist.size();
        for (int k = 0; k < 5; k++) begin
            set_m(1, 1'b1, k < 4, 1'b1, AW'(10'h020 + k), $urandom, 4'hF);
            if (k == 2) set_m(0, 1'b1, 1'b0, 1'b0, 10'h020, 32'd0, 4'hF);
            step();
        end
        req[1] = 1'b0;
        step();
        req[0] = 1'b0;
        step();
        q = '{1, 1, 1, 1, 1, 0};
        check_seq("burst", s, q);

        // Write then read of the same word on consecutive cycles
        set_m(0, 1'b1, 1'b0, 1'b1, 10'h005, 32'h1234_5678, 4'hF);
        step();
        set_m(0, 1'b1, 1'b0, 1'b0, 10'h005, 32'd0, 4'hF);
        step();
        req[0] = 1'b0;
        chk("raw_rvalid", {31'd0, m0_rvalid}, 32'd1);
        chk("raw_rdata", m0_rdata, 32'h1234_5678);
        step();

        // Preemption after MAX_BURST locked beats
        set_m(1, 1'b1, 1'b1, 1'b1, 10'h040, $urandom, 4'hF);
        set_m(0, 1'b1, 1'b0, 1'b0, 10'h041, 32'd0, 4'hF);
        s = ghist.size();
        repeat (11) step();
        req = '0;
        step();
        q = '{1, 1, 1, 1, 1, 1, 1, 1, 0, 1, 1};
        check_seq("preempt", s, q);

        // Owner dropping req releases the lock (other requester present)
        s = ghist.size();
        set_m(0, 1'b1, 1'b1, 1'b1, 10'h050, $urandom, 4'h3);
        step();
        req[0] = 1'b0;
        set_m(1, 1'b1, 1'b0, 1'b0, 10'h050, 32'd0, 4'hF);
        step();
        req[1] = 1'b0;
        step();
        q = '{0, 1, -1};
        check_seq("idle_a", s, q);

        // Owner idle for one cycle, then both ask: round-robin, not the lock, decides
        s = ghist.size();
        set_m(0, 1'b1, 1'b1, 1'b1, 10'h051, $urandom, 4'hF);
        step();
        req = '0;
        step();
        set_m(0, 1'b1, 1'b0, 1'b0, 10'h051, 32'd0, 4'hF);
        set_m(1, 1'b1, 1'b0, 1'b0, 10'h052, 32'd0, 4'hF);
        step();
        req[1] = 1'b0;
        step();
        req[0] = 1'b0;
        step();
        q = '{0, -1, 1, 0, -1};
        check_seq("idle_b", s, q);

        // Asynchronous reset right after a read grant
        set_m(0, 1'b1, 1'b0, 1'b0, 10'h010, 32'd0, 4'hF);
        step();
        resetn = 1'b0;
        set_m(1, 1'b1, 1'b0, 1'b0, 10'h011, 32'd0, 4'hF);
        #1;
        chk("arst_rvalid", {31'd0, m0_rvalid}, 32'd0);
        chk("arst_m0_gnt", {31'd0, m0_gnt}, 32'd0);
        chk("arst_m1_gnt", {31'd0, m1_gnt}, 32'd0);
        chk("arst_rden", {31'd0, ram_rden}, 32'd0);
        step();
        step();
        resetn = 1'b1;
        s = ghist.size();
        step();
        req[0] = 1'b0;
        step();
        req = '0;
        step();
        q = '{0, 1};
        check_seq("post_rst", s, q);

        // Randomized traffic with varying request and lock density
        preq  = 60;
        plock = 50;
        for (int c = 0; c < 3000; c++) begin
            if (c % 250 == 0) begin
                preq  = $urandom_range(40, 97);
                plock = $urandom_range(10, 95);
            end
            for (int m = 0; m < 2; m++) begin
                if (!(req[m] && !seen_gnt[m])) begin
                    req[m]  = ($urandom_range(0, 99) < preq);
                    lock[m] = ($urandom_range(0, 99) < plock);
                    wren[m] = 1'($urandom_range(0, 1));
                    addr[m] = AW'($urandom_range(0, 15));
                    be[m]   = 4'($urandom);
                    wdat[m] = $urandom;
                end
            end
            step();
        end
        req = '0;
        step();
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
